fifo_1r1w_ctrl: RTL



---
 rtl/fifo_1r1w_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fifo_1r1w_ctrl.sv
// First-word-fall-through FIFO built around a 1R1W synchronous RAM.
// The head word sits in the RAM output register, so a write reaches valid_o two cycles later.

module ram_1r1w_sync #(
  parameter int unsigned width_p  = 8,
  parameter int unsigned depth_p  = 512,
  parameter int unsigned addr_w_p = $clog2(depth_p)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                wr_valid_i,
  input  logic [addr_w_p-1:0] wr_addr_i,
  input  logic [width_p-1:0]  wr_data_i,
  input  logic                rd_valid_i,
  input  logic [addr_w_p-1:0] rd_addr_i,
  output logic [width_p-1:0]  rd_data_o
);

  logic [width_p-1:0] mem_q [depth_p];
  logic [width_p-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_valid_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Output register only changes on a read, which keeps the FIFO head stable under stall.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_data_q <= '0;
    end else if (rd_valid_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

module fifo_1r1w_ctrl #(
  parameter int unsigned width_p = 8,
  parameter int unsigned depth_p = 512
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         valid_i,
  input  logic [width_p-1:0]           data_i,
  output logic                         ready_o,
  output logic                         valid_o,
  output logic [width_p-1:0]           data_o,
  input  logic                         ready_i,
  output logic [$clog2(depth_p+2)-1:0] count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned AW = $clog2(depth_p);
  localparam int unsigned CW = $clog2(depth_p + 1);
  localparam int unsigned OW = $clog2(depth_p + 2);

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(depth_p);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] ram_count_q, ram_count_d;
  logic          head_v_q, head_v_d;

  logic push;
  logic pop;
  logic issue;
  logic ram_full;
  logic ram_empty;

  assign ram_full  = (ram_count_q == CNT_DEPTH);
  assign ram_empty = (ram_count_q == '0);

  assign ready_o = ~ram_full;
  assign valid_o = head_v_q;
  assign push    = valid_i & ready_o;
  assign pop     = head_v_q & ready_i;
  // Only words committed in earlier cycles are counted, so a read never hits the slot being written.
  assign issue   = ~ram_empty & (~head_v_q | ready_i);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_count_d = ram_count_q;
    head_v_d    = issue | (head_v_q & ~pop);

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    case ({push, issue})
      2'b10:   ram_count_d = ram_count_q + CNT_ONE;
      2'b01:   ram_count_d = ram_count_q - CNT_ONE;
      default: ram_count_d = ram_count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      head_v_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      head_v_q    <= head_v_d;
    end
  end

  assign count_o = OW'(ram_count_q) + OW'(head_v_q);
  assign full_o  = ram_full;
  assign empty_o = ram_empty & ~head_v_q;

  ram_1r1w_sync #(
    .width_p (width_p),
    .depth_p (depth_p),
    .addr_w_p(AW)
  ) u_ram (
    .clk_i     (clk_i),
    .reset_i   (~reset_n_i),
    .wr_valid_i(push),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data_i),
    .rd_valid_i(issue),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (data_o)
  );

endmodule
